// File: rtl/reduce_tree.sv
// reduce_tree: pipelined IN_SIZE-lane reduction (OR/AND/XOR/umax/smax) with a BLOCK_BEATS accumulator.
// Optional macro REDUCE_TREE_ABS_IN_EN: each lane is replaced by its magnitude ahead of level 0.
module reduce_tree #(
    parameter int IN_SIZE     = 4,
    parameter int IN_WIDTH    = 8,
    parameter int MODE        = 0,
    parameter int BLOCK_BEATS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] data_in [IN_SIZE],
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic [IN_WIDTH-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                block_last
);
    localparam int LEVELS = $clog2(IN_SIZE);
`ifdef REDUCE_TREE_ABS_IN_EN
    localparam int OP = (MODE == 4) ? 3 : MODE;
`else
    localparam int OP = MODE;
`endif

    if (MODE < 0 || MODE > 4) begin : g_bad_mode
        $error("reduce_tree: unsupported MODE %0d", MODE);
    end
    if (IN_SIZE < 1 || BLOCK_BEATS < 1) begin : g_bad_size
        $error("reduce_tree: IN_SIZE and BLOCK_BEATS must be >= 1");
    end

    function automatic logic [IN_WIDTH-1:0] op(input logic [IN_WIDTH-1:0] a,
                                               input logic [IN_WIDTH-1:0] b);
        case (OP)
            0:       return a | b;
            1:       return a & b;
            2:       return a ^ b;
            3:       return (a > b) ? a : b;
            default: return ($signed(a) > $signed(b)) ? a : b;
        endcase
    endfunction

    logic [IN_WIDTH-1:0] lanes [IN_SIZE];
    always_comb begin
        for (int k = 0; k < IN_SIZE; k++) begin
`ifdef REDUCE_TREE_ABS_IN_EN
            lanes[k] = data_in[k][IN_WIDTH-1] ? (~data_in[k] + IN_WIDTH'(1)) : data_in[k];
`else
            lanes[k] = data_in[k];
`endif
        end
    end

    // Bit i of each vector describes the boundary feeding level i; bit LEVELS feeds the accumulator.
    logic [LEVELS:0] vld_pipe;
    logic [LEVELS:0] rdy_pipe;
    logic            out_v;
    logic [IN_WIDTH-1:0] out_d;

    assign vld_pipe[0]      = data_in_valid;
    assign rdy_pipe[LEVELS] = !out_v || data_out_ready;
    assign data_in_ready    = rdy_pipe[0];

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int NI = (IN_SIZE + (1 << i) - 1) >> i;
        localparam int NO = (NI + 1) / 2;
        logic [IN_WIDTH-1:0] d   [NI];
        logic [IN_WIDTH-1:0] nxt [NO];
        logic [IN_WIDTH-1:0] q   [NO];
        logic                vq;

        if (i == 0) begin : g_src
            assign d = lanes;
        end else begin : g_src
            assign d = g_lvl[i-1].q;
        end

        // Odd trailing word bypasses the operator rather than meeting an identity constant.
        for (genvar k = 0; k < NO; k++) begin : g_pair
            if (2*k + 1 < NI) begin : g_op
                assign nxt[k] = op(d[2*k], d[2*k+1]);
            end else begin : g_pass
                assign nxt[k] = d[2*k];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vq <= 1'b0;
                for (int k = 0; k < NO; k++) q[k] <= '0;
            end else if (rdy_pipe[i]) begin
                vq <= vld_pipe[i];
                if (vld_pipe[i]) q <= nxt;
            end
        end

        assign vld_pipe[i+1] = vq;
        assign rdy_pipe[i]   = !vq || rdy_pipe[i+1];
    end

    logic [IN_WIDTH-1:0] tree_out;
    if (LEVELS == 0) begin : g_root
        assign tree_out = lanes[0];
    end else begin : g_root
        assign tree_out = g_lvl[LEVELS-1].q[0];
    end

    logic                tree_fire;
    logic                res_fire;
    logic [IN_WIDTH-1:0] res;
    assign tree_fire = vld_pipe[LEVELS] && rdy_pipe[LEVELS];

    if (BLOCK_BEATS == 1) begin : g_acc
        assign res      = tree_out;
        assign res_fire = tree_fire;
    end else begin : g_acc
        localparam int BW = $clog2(BLOCK_BEATS);
        localparam logic [BW-1:0] LAST = BW'(BLOCK_BEATS - 1);
        logic [BW-1:0]       beat;
        logic [IN_WIDTH-1:0] acc;

        assign res      = (beat == '0) ? tree_out : op(acc, tree_out);
        assign res_fire = tree_fire && (beat == LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                beat <= '0;
                acc  <= '0;
            end else if (tree_fire) begin
                acc  <= res;
                beat <= (beat == LAST) ? '0 : beat + 1'b1;
            end
        end
    end

    // res_fire only happens when the output slot is empty or draining this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            out_d <= '0;
        end else if (res_fire) begin
            out_v <= 1'b1;
            out_d <= res;
        end else if (data_out_ready) begin
            out_v <= 1'b0;
        end
    end

    assign data_out       = out_d;
    assign data_out_valid = out_v;
    assign block_last     = out_v;
endmodule

// File: tb/tb_reduce_tree.sv
// Scoreboard bench for reduce_tree: five configurations, directed vectors, backpressure and mid-block reset.
module tb_reduce_tree;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] din0 [5];
    logic [7:0] din1 [4];
    logic [7:0] din2 [4];
    logic [7:0] din3 [2];
    logic [7:0] din4 [3];
    logic [4:0] ivld, irdy, ovld, ordy, blast;
    logic [7:0] dout [5];

    reduce_tree #(.IN_SIZE(5), .IN_WIDTH(8), .MODE(0), .BLOCK_BEATS(1)) u0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_in_valid(ivld[0]), .data_in_ready(irdy[0]),
        .data_out(dout[0]), .data_out_valid(ovld[0]), .data_out_ready(ordy[0]), .block_last(blast[0]));
    reduce_tree #(.IN_SIZE(4), .IN_WIDTH(8), .MODE(4), .BLOCK_BEATS(1)) u1 (
        .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(ivld[1]), .data_in_ready(irdy[1]),
        .data_out(dout[1]), .data_out_valid(ovld[1]), .data_out_ready(ordy[1]), .block_last(blast[1]));
    reduce_tree #(.IN_SIZE(4), .IN_WIDTH(8), .MODE(3), .BLOCK_BEATS(1)) u2 (
        .clk(clk), .rst(rst), .data_in(din2), .data_in_valid(ivld[2]), .data_in_ready(irdy[2]),
        .data_out(dout[2]), .data_out_valid(ovld[2]), .data_out_ready(ordy[2]), .block_last(blast[2]));
    reduce_tree #(.IN_SIZE(2), .IN_WIDTH(8), .MODE(1), .BLOCK_BEATS(3)) u3 (
        .clk(clk), .rst(rst), .data_in(din3), .data_in_valid(ivld[3]), .data_in_ready(irdy[3]),
        .data_out(dout[3]), .data_out_valid(ovld[3]), .data_out_ready(ordy[3]), .block_last(blast[3]));
    reduce_tree #(.IN_SIZE(3), .IN_WIDTH(8), .MODE(3), .BLOCK_BEATS(1)) u4 (
        .clk(clk), .rst(rst), .data_in(din4), .data_in_valid(ivld[4]), .data_in_ready(irdy[4]),
        .data_out(dout[4]), .data_out_valid(ovld[4]), .data_out_ready(ordy[4]), .block_last(blast[4]));

`ifdef REDUCE_TREE_ABS_IN_EN
    localparam logic [7:0] E_SMAX = 8'h80, E_UMAX = 8'h80, E_BLK = 8'h00, E_RST = 8'h00;
    localparam logic [7:0] E_A0 = 8'h80, E_A1 = 8'h05;
`else
    localparam logic [7:0] E_SMAX = 8'h05, E_UMAX = 8'hF0, E_BLK = 8'h76, E_RST = 8'h30;
    localparam logic [7:0] E_A0 = 8'hFB, E_A1 = 8'hFB;
`endif

    typedef struct {
        int         id;
        logic [7:0] val;
        int         hs;
        int         lat;
    } ent_t;
    ent_t sb[$];

    int tests = 0, errors = 0, cyc = 0;
    bit bp_en = 1'b0;
    logic [7:0] vec [5];
    bit   [4:0] held;
    logic [7:0] hval [5];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bp_en) begin #1 ordy[1] = 1'($urandom_range(0, 1)); end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: stability while stalled, then pop-and-compare on each output handshake.
    always @(negedge clk) begin
        if (rst) held = '0;
        else for (int k = 0; k < 5; k++) begin
            if (!ovld[k]) held[k] = 1'b0;
            else begin
                chk($sformatf("block_last[%0d]", k), blast[k], 1);
                if (held[k]) chk($sformatf("stall_stable[%0d]", k), dout[k], hval[k]);
                if (ordy[k]) begin
                    int idx = -1;
                    for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].id == k) idx = j;
                    if (idx < 0) begin
                        tests++; errors++;
                        $display("FAIL unexpected_out[%0d]: got %0h expected none", k, dout[k]);
                    end else begin
                        chk($sformatf("data[%0d]", k), dout[k], sb[idx].val);
                        if (sb[idx].lat >= 0) chk($sformatf("latency[%0d]", k), cyc - sb[idx].hs, sb[idx].lat);
                        sb.delete(idx);
                    end
                    held[k] = 1'b0;
                end else begin
                    held[k] = 1'b1;
                    hval[k] = dout[k];
                end
            end
        end
    end

    task automatic send(input int id, input bit push, input logic [7:0] ev, input int lat);
        int w = 0;
        @(negedge clk);
        case (id)
            0: for (int j = 0; j < 5; j++) din0[j] = vec[j];
            1: for (int j = 0; j < 4; j++) din1[j] = vec[j];
            2: for (int j = 0; j < 4; j++) din2[j] = vec[j];
            3: for (int j = 0; j < 2; j++) din3[j] = vec[j];
            default: for (int j = 0; j < 3; j++) din4[j] = vec[j];
        endcase
        ivld[id] = 1'b1;
        while (!irdy[id] && w < 200) begin @(negedge clk); w++; end
        if (!irdy[id]) begin
            tests++; errors++;
            $display("FAIL in_ready_timeout[%0d]: got 0 expected 1", id);
            ivld[id] = 1'b0;
            return;
        end
        if (push) sb.push_back('{id, ev, cyc, lat});
        @(posedge clk);
    endtask

    task automatic idle(input int id);
        @(negedge clk);
        ivld[id] = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", ovld[3], 0);
        chk("arst_block_last", blast[3], 0);
        chk("arst_data_out", dout[3], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] model_max4();
        logic [7:0] m, x;
        m = 8'h00;
        for (int j = 0; j < 4; j++) begin
            x = vec[j];
`ifdef REDUCE_TREE_ABS_IN_EN
            if (x[7]) x = -x;
            if (j == 0 || x > m) m = x;
`else
            if (j == 0 || $signed(x) > $signed(m)) m = x;
`endif
        end
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; ivld = '0; ordy = '1; held = '0;
        vec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 5; j++) begin din0[j] = '0; hval[j] = '0; end
        for (int j = 0; j < 4; j++) begin din1[j] = '0; din2[j] = '0; end
        for (int j = 0; j < 2; j++) din3[j] = '0;
        for (int j = 0; j < 3; j++) din4[j] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rst_out_valid[%0d]", k), ovld[k], 0);
            chk($sformatf("rst_data_out[%0d]", k), dout[k], 0);
            chk($sformatf("rst_block_last[%0d]", k), blast[k], 0);
            chk($sformatf("rst_in_ready[%0d]", k), irdy[k], 1);
        end

        // OR tree, 5 lanes: latency LEVELS+1 and odd trailing lane pass-through
        vec = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10}; send(0, 1, 8'h1F, 4);
        vec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}; send(0, 1, 8'h5A, 4);
        idle(0);

        // signed vs unsigned max on the same lanes
        vec = '{8'hF0, 8'h05, 8'h80, 8'h03, 8'h00};
        send(1, 1, E_SMAX, -1); idle(1);
        send(2, 1, E_UMAX, -1); idle(2);

        // 3-lane umax (magnitude inputs when the abs option is built in)
        vec = '{8'hFB, 8'h04, 8'h80, 8'h00, 8'h00}; send(4, 1, E_A0, -1);
        vec = '{8'hFB, 8'h04, 8'h01, 8'h00, 8'h00}; send(4, 1, E_A1, -1);
        idle(4);

        // 3-beat AND block, output held by ordy=0
        ordy[3] = 1'b0;
        vec = '{8'hFF, 8'hF7, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        vec = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        idle(3);
        repeat (3) @(negedge clk);
        chk("no_early_out", ovld[3], 0);
        vec = '{8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        idle(3);
        repeat (3) @(negedge clk);
        chk("block_out_valid", ovld[3], 1);
        chk("block_out_data", dout[3], E_BLK);
        chk("block_out_last", blast[3], 1);

        // reset while the output is held and a new beat waits in the tree
        vec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        idle(3);
        repeat (2) @(negedge clk);
        chk("held_valid", ovld[3], 1);
        chk("held_data", dout[3], E_BLK);
        pulse_rst();

        // reset after beat 2 of a block; zero beats would poison the AND if they leaked
        ordy[3] = 1'b1;
        vec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(3, 0, 8'h00, -1); send(3, 0, 8'h00, -1);
        idle(3);
        repeat (4) @(negedge clk);
        pulse_rst();
        @(negedge clk);
        chk("post_rst_in_ready", irdy[3], 1);
        vec = '{8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        vec = '{8'h3F, 8'hFF, 8'h00, 8'h00, 8'h00}; send(3, 0, 8'h00, -1);
        vec = '{8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00}; send(3, 1, E_RST, 2);
        idle(3);

        // backpressure: 20 random vectors with ordy toggling
        bp_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int j = 0; j < 4; j++) vec[j] = 8'($urandom);
            send(1, 1, model_max4(), -1);
        end
        idle(1);
        @(negedge clk);
        bp_en = 1'b0;
        @(posedge clk);
        #3 ordy[1] = 1'b1;

        w = 0;
        while (sb.size() > 0 && w < 500) begin @(negedge clk); w++; end
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
